// File: rtl/pipeline_control_if.sv
// Handshake bundle between the LC-3b pipeline datapath and its stall/flush sequencer.
// master = sequencer (drives load/flush), slave = datapath (drives hazard/memory status).
interface pipeline_control_if;
  logic imem_read;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  logic mispredict;
  logic load_use;
  logic cc_write;

  logic load_pc;
  logic load_if_id;
  logic load_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic load_cc_mem_wb;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_ex_mem;

  modport master (
    input  imem_read, imem_resp, dmem_req, dmem_resp, mispredict, load_use, cc_write,
    output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, load_cc_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem
  );

  modport slave (
    output imem_read, imem_resp, dmem_req, dmem_resp, mispredict, load_use, cc_write,
    input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, load_cc_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem
  );
endinterface

// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline with a memory-stall watchdog.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_control #(
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_control_if.master   bus,
  output logic                 hang_err,
  output logic [1:0]           ctl_state,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count,
  output logic [31:0]          bubble_count
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HUNG     = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_FREEZE,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_ADVANCE
  } act_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          hang_err_q, hang_err_d;
  logic          mem_busy;
  act_e          resolved_act;
  act_e          act;

  assign mem_busy = (bus.imem_read & ~bus.imem_resp) | (bus.dmem_req & ~bus.dmem_resp);

  // Hazard choice once memory is quiet: a mispredict squashes any bubble target.
  always_comb begin
    resolved_act = ACT_ADVANCE;
    if (bus.mispredict) begin
      resolved_act = ACT_FLUSH;
    end else if (bus.load_use) begin
      resolved_act = ACT_BUBBLE;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    hang_err_d = hang_err_q;
    act        = ACT_IDLE;
    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          act        = ACT_FREEZE;
          state_d    = MEM_WAIT;
          wait_cnt_d = CW'(1);
        end else begin
          act = resolved_act;
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          act = ACT_FREEZE;
          if (wait_cnt_q == WAIT_MAX) begin
            state_d    = HUNG;
            hang_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + CW'(1);
          end
        end else begin
          act        = resolved_act;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end
      HUNG: begin
        act = ACT_IDLE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
    if (reset) begin
      act = ACT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      hang_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      hang_err_q <= hang_err_d;
    end
  end

  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem;

  // Freeze and idle both hold every register; they differ only in what the counters see.
  always_comb begin
    load_pc      = 1'b0;
    load_if_id   = 1'b0;
    load_id_ex   = 1'b0;
    load_ex_mem  = 1'b0;
    load_mem_wb  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    unique case (act)
      ACT_FLUSH: begin
        load_pc      = 1'b1;
        load_if_id   = 1'b1;
        load_id_ex   = 1'b1;
        load_ex_mem  = 1'b1;
        load_mem_wb  = 1'b1;
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end
      ACT_BUBBLE: begin
        load_id_ex  = 1'b1;
        flush_id_ex = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      ACT_ADVANCE: begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        load_id_ex  = 1'b1;
        load_ex_mem = 1'b1;
        load_mem_wb = 1'b1;
      end
      default: begin
        load_pc = 1'b0;
      end
    endcase
  end

  assign bus.load_pc        = load_pc;
  assign bus.load_if_id     = load_if_id;
  assign bus.load_id_ex     = load_id_ex;
  assign bus.load_ex_mem    = load_ex_mem;
  assign bus.load_mem_wb    = load_mem_wb;
  assign bus.load_cc_mem_wb = load_mem_wb & bus.cc_write;
  assign bus.flush_if_id    = flush_if_id;
  assign bus.flush_id_ex    = flush_id_ex;
  assign bus.flush_ex_mem   = flush_ex_mem;

  assign hang_err  = hang_err_q;
  assign ctl_state = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + {31'd0, act == ACT_FREEZE};
    flush_count_d  = flush_count_q + {31'd0, act == ACT_FLUSH};
    bubble_count_d = bubble_count_q + {31'd0, act == ACT_BUBBLE};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
  assign bubble_count = bubble_count_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed vector table, multi-cycle
// sequences, then random stimulus against a cycle-level behavioural model.
module tb_pipeline_control;

  localparam int TIMEOUT = 8;

  localparam logic [8:0] ZERO   = 9'b00000_0_000;
  localparam logic [8:0] ADV    = 9'b11111_0_000;
  localparam logic [8:0] ADV_CC = 9'b11111_1_000;
  localparam logic [8:0] FLU    = 9'b11111_0_111;
  localparam logic [8:0] FLU_CC = 9'b11111_1_111;
  localparam logic [8:0] BUB    = 9'b00111_0_010;
  localparam logic [8:0] BUB_CC = 9'b00111_1_010;

  typedef struct packed {
    logic reset;
    logic imem_read;
    logic imem_resp;
    logic dmem_req;
    logic dmem_resp;
    logic mispredict;
    logic load_use;
    logic cc_write;
  } in_t;

  typedef struct {
    in_t        in;
    logic [8:0] ctl;
    logic [1:0] st;
    logic       hang;
    string      name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        hang_err;
  logic [1:0]  ctl_state;
  logic [31:0] stall_cycles, flush_count, bubble_count;

  int passCount = 0;
  int checkCount = 0;

  // Model: length of the current unbroken run of busy cycles, sticky hang, counters.
  int          busy_run = 0;
  bit          m_hung = 1'b0;
  logic [31:0] m_stall = '0, m_flush = '0, m_bubble = '0;

  always #5 clk = ~clk;

  pipeline_control_if bus ();

  pipeline_control #(.TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .hang_err     (hang_err),
    .ctl_state    (ctl_state),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count),
    .bubble_count (bubble_count)
  );

  function automatic in_t mk(bit r, bit ir, bit irs, bit dr, bit drs, bit mp, bit lu, bit cc);
    in_t v;
    v = '{r, ir, irs, dr, drs, mp, lu, cc};
    return v;
  endfunction

  function automatic bit isBusy(in_t i);
    return (i.imem_read && !i.imem_resp) || (i.dmem_req && !i.dmem_resp);
  endfunction

  function automatic logic [8:0] modelCtl(in_t i);
    logic [4:0] ld;
    logic [2:0] fl;
    if (i.reset || m_hung || isBusy(i)) return ZERO;
    if (i.mispredict) begin
      ld = 5'b11111;
      fl = 3'b111;
    end else if (i.load_use) begin
      ld = 5'b00111;
      fl = 3'b010;
    end else begin
      ld = 5'b11111;
      fl = 3'b000;
    end
    return {ld, ld[0] & i.cc_write, fl};
  endfunction

  function automatic logic [1:0] modelState();
    if (m_hung) return 2'd2;
    if (busy_run > 0) return 2'd1;
    return 2'd0;
  endfunction

  task automatic modelUpdate(in_t i);
    if (i.reset) begin
      busy_run = 0;
      m_hung   = 1'b0;
      m_stall  = '0;
      m_flush  = '0;
      m_bubble = '0;
    end else if (!m_hung) begin
      if (isBusy(i)) begin
        m_stall  = m_stall + 32'd1;
        busy_run = busy_run + 1;
        if (busy_run == TIMEOUT + 1) m_hung = 1'b1;
      end else begin
        busy_run = 0;
        if (i.mispredict) m_flush = m_flush + 32'd1;
        else if (i.load_use) m_bubble = m_bubble + 32'd1;
      end
    end
  endtask

  task automatic applyStimulus(in_t i);
    reset          = i.reset;
    bus.imem_read  = i.imem_read;
    bus.imem_resp  = i.imem_resp;
    bus.dmem_req   = i.dmem_req;
    bus.dmem_resp  = i.dmem_resp;
    bus.mispredict = i.mispredict;
    bus.load_use   = i.load_use;
    bus.cc_write   = i.cc_write;
  endtask

  task automatic checkOutput(string name, logic [8:0] exp_ctl, logic [1:0] exp_st,
                             logic exp_hang, bit chk_st);
    logic [8:0]  got;
    logic [95:0] exp_cnt;
    got = {bus.load_pc, bus.load_if_id, bus.load_id_ex, bus.load_ex_mem, bus.load_mem_wb,
           bus.load_cc_mem_wb, bus.flush_if_id, bus.flush_id_ex, bus.flush_ex_mem};
    checkCount++;
    if (got === exp_ctl && (!chk_st || (ctl_state === exp_st && hang_err === exp_hang)))
      passCount++;
    else
      $display("[TB] FAIL %s @%0t: ctl=%b state=%0d hang=%b, want ctl=%b state=%0d hang=%b",
               name, $time, got, ctl_state, hang_err, exp_ctl, exp_st, exp_hang);
`ifdef PIPE_PERF_CNT_EN
    exp_cnt = {m_stall, m_flush, m_bubble};
`else
    exp_cnt = '0;
`endif
    checkCount++;
    if ({stall_cycles, flush_count, bubble_count} === exp_cnt)
      passCount++;
    else
      $display("[TB] FAIL %s_cnt @%0t: stall/flush/bubble=%0d/%0d/%0d, want %0d/%0d/%0d",
               name, $time, stall_cycles, flush_count, bubble_count,
               exp_cnt[95:64], exp_cnt[63:32], exp_cnt[31:0]);
  endtask

  task automatic step(in_t i, logic [8:0] exp_ctl, logic [1:0] exp_st, logic exp_hang,
                      string name, bit chk_st);
    applyStimulus(i);
    @(negedge clk);
    checkOutput(name, exp_ctl, exp_st, exp_hang, chk_st);
    @(posedge clk);
    modelUpdate(i);
    #1;
  endtask

  in_t  idle;
  vec_t vecs[$];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    vecs.push_back('{mk(0,0,0,0,0,0,0,0), ADV,    2'd0, 1'b0, "idle"});
    vecs.push_back('{mk(0,0,0,0,0,0,0,1), ADV_CC, 2'd0, 1'b0, "adv_cc"});
    vecs.push_back('{mk(0,0,0,0,0,1,0,0), FLU,    2'd0, 1'b0, "mispredict"});
    vecs.push_back('{mk(0,0,0,0,0,1,0,1), FLU_CC, 2'd0, 1'b0, "mispredict_cc"});
    vecs.push_back('{mk(0,0,0,0,0,0,1,0), BUB,    2'd0, 1'b0, "load_use"});
    vecs.push_back('{mk(0,0,0,0,0,0,1,1), BUB_CC, 2'd0, 1'b0, "load_use_cc"});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0), ADV,    2'd0, 1'b0, "after_bubble"});
    vecs.push_back('{mk(0,0,0,0,0,1,1,0), FLU,    2'd0, 1'b0, "mp_beats_lu"});
    vecs.push_back('{mk(0,1,1,0,0,0,0,0), ADV,    2'd0, 1'b0, "imem_hit"});
    vecs.push_back('{mk(0,0,0,1,1,0,1,0), BUB,    2'd0, 1'b0, "dmem_hit_lu"});
    vecs.push_back('{mk(0,0,0,0,0,0,1,0), BUB,    2'd0, 1'b0, "lu_back2back"});
    vecs.push_back('{mk(0,0,1,0,1,0,0,0), ADV,    2'd0, 1'b0, "stray_resp"});
    vecs.push_back('{mk(1,1,0,0,0,1,0,1), ZERO,   2'd0, 1'b0, "reset_busy"});
    vecs.push_back('{mk(0,0,0,0,0,0,0,0), ADV,    2'd0, 1'b0, "post_reset"});

    for (int k = 0; k < 2; k++) step(mk(1,0,0,0,0,0,0,0), ZERO, 2'd0, 1'b0, "reset_hold", 1'b0);
    step(idle, ADV, 2'd0, 1'b0, "first_run", 1'b1);

    for (int k = 0; k < vecs.size(); k++)
      step(vecs[k].in, vecs[k].ctl, vecs[k].st, vecs[k].hang, vecs[k].name, 1'b1);

    $display("[TB] D-cache stall of 5 cycles with cc_write");
    for (int k = 0; k < 5; k++)
      step(mk(0,0,0,1,0,0,0,1), ZERO, (k == 0) ? 2'd0 : 2'd1, 1'b0, "dstall", 1'b1);
    step(mk(0,0,0,1,1,0,0,1), ADV_CC, 2'd1, 1'b0, "dresp", 1'b1);
    step(idle, ADV, 2'd0, 1'b0, "dafter", 1'b1);

    $display("[TB] mispredict held across a 3-cycle fetch stall");
    for (int k = 0; k < 3; k++)
      step(mk(0,1,0,0,0,1,0,0), ZERO, (k == 0) ? 2'd0 : 2'd1, 1'b0, "mp_frozen", 1'b1);
    step(mk(0,1,1,0,0,1,0,0), FLU, 2'd1, 1'b0, "mp_taken", 1'b1);
    step(idle, ADV, 2'd0, 1'b0, "mp_after", 1'b1);

    $display("[TB] longest stall that still recovers");
    for (int k = 0; k < TIMEOUT; k++)
      step(mk(0,1,0,0,0,0,0,0), ZERO, (k == 0) ? 2'd0 : 2'd1, 1'b0, "edge_stall", 1'b1);
    step(mk(0,1,1,0,0,0,1,0), BUB, 2'd1, 1'b0, "edge_resp", 1'b1);
    step(idle, ADV, 2'd0, 1'b0, "edge_after", 1'b1);

    $display("[TB] watchdog timeout");
    for (int k = 0; k < TIMEOUT + 1; k++)
      step(mk(0,1,0,0,0,0,0,0), ZERO, (k == 0) ? 2'd0 : 2'd1, 1'b0, "to_stall", 1'b1);
    step(mk(0,1,1,0,0,0,0,1), ZERO, 2'd2, 1'b1, "hung_resp", 1'b1);
    step(mk(0,0,0,0,0,1,0,0), ZERO, 2'd2, 1'b1, "hung_mp", 1'b1);
    step(idle, ZERO, 2'd2, 1'b1, "hung_idle", 1'b1);
    step(mk(1,0,0,0,0,0,0,0), ZERO, 2'd2, 1'b1, "hung_reset", 1'b1);
    step(idle, ADV, 2'd0, 1'b0, "unhung", 1'b1);

    $display("[TB] random stimulus");
    for (int n = 0; n < 3000; n++) begin
      in_t r;
      r.reset      = ($urandom_range(0, 199) == 0);
      r.imem_read  = ($urandom_range(0, 99) < 50);
      r.imem_resp  = ($urandom_range(0, 99) < 40);
      r.dmem_req   = ($urandom_range(0, 99) < 30);
      r.dmem_resp  = ($urandom_range(0, 99) < 50);
      r.mispredict = ($urandom_range(0, 99) < 15);
      r.load_use   = ($urandom_range(0, 99) < 20);
      r.cc_write   = ($urandom_range(0, 99) < 50);
      step(r, modelCtl(r), modelState(), m_hung, "rand", 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
